div_unit: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the Execute stage alongside the ALU.
- Its stall output drives, inverted, the enable of the PC, IF/ID and ID/EX pipeline registers, and the flush of EX/MEM. This holds the pipeline while the divider iterates.
- The result is muxed onto the Execute result bus in the cycle done is asserted.

---
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Purpose : iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency : WIDTH+1 cycles from accepted start to done; 1 cycle for divide-by-zero / signed overflow.
// Backpressure: stall holds the pipeline while a start is pending in IDLE or the divider iterates.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start           divide-class instruction present in EX (level, held while stalled)
//   op              00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   a, b            dividend (rs1) and divisor (rs2)
//   stall           combinational pipeline hold
//   busy            registered; high in DIVIDE and DONE
//   done            registered single-cycle result strobe
//   result          registered quotient or remainder, valid while done=1
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic             r_rem_sel;   // 1: result is the remainder
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  // Operand conditioning in IDLE.
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_spec_res;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_div0   = (b == '0);
  assign w_ovf    = w_signed & (a == MIN_VAL) & (b == '1);

  // Divide-by-zero: quotient all ones, remainder = a.
  // Signed overflow: quotient = a (MIN), remainder = 0.
  assign w_spec_res = op[1] ? (w_div0 ? a : '0) : (w_div0 ? '1 : a);

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits in WIDTH+1 bits and the trial's MSB is its sign.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_final;

  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_div};
  assign w_ge      = ~w_trial[WIDTH];
  assign w_rem_nx  = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};
  assign w_quo_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_final   = r_rem_sel ? w_rem_fix : w_quo_fix;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rem_sel <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem_sel <= op[1];
            r_busy    <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_neg_q <= (op == 2'b00) & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r <= (op == 2'b10) & a[WIDTH-1];
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_div   <= w_b_mag;
              r_cnt   <= CW'(WIDTH);
              r_state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
          // Last iteration: the corrected result is registered directly.
          if (r_cnt == CW'(1)) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // start is still high here as the instruction leaves EX; ignore it.
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall  = ((r_state == S_IDLE) && start) || (r_state == S_DIVIDE);
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Purpose : self-checking bench for div_unit against an arithmetic reference model.
// Latency : checks WIDTH+1 / 1 cycle start-to-done latency per operation.
// Backpressure: checks stall over every cycle of each operation.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  // Reference: RISC-V M semantics using wide signed/unsigned arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_DIV:  return (y == 0) ? '1 : W'(sx / sy);
      OP_REM:  return (y == 0) ? x  : W'(sx % sy);
      OP_DIVU: return (y == 0) ? '1 : x / y;
      default: return (y == 0) ? x  : x % y;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    if (y == 0) return 1;
    if (!o[0] && x == MINV && y == '1) return 1;
    return W + 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return MINV;
      4: return W'($urandom_range(0, 20));
      5: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drives one operation; cycle 0 is the cycle in which start is first seen in IDLE.
  task automatic exec(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input bit chained, input bit keep, input bit toggle,
                      output logic [W-1:0] res, output int lat, output int stall_err,
                      output logic busy_at_done);
    if (!chained) begin
      @(posedge clk); #1;
    end
    start = 1'b1; op = o; a = x; b = y;
    lat = -1; stall_err = 0; res = '0; busy_at_done = 1'b0;
    for (int c = 0; c < W + 20; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c; res = result; busy_at_done = busy;
        if (stall !== 1'b0) stall_err++;
        break;
      end
      if (stall !== 1'b1) stall_err++;
      @(posedge clk); #1;
      if (toggle) begin a = $urandom; b = $urandom; op = 2'($urandom); end
    end
    @(posedge clk); #1;
    if (!keep) start = 1'b0;
  endtask

  logic [W-1:0] r_res;
  int           r_lat, r_serr;
  logic         r_bsy;

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (result !== '0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", result); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_divu_basic();
    exec(OP_DIVU, 100, 7, 0, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== 32'd14) begin miscompares++; $display("FAIL divu_result: got %h expected %h", r_res, 32'd14); end
    vectors++; if (r_lat !== 33) begin miscompares++; $display("FAIL divu_latency: got %0d expected 33", r_lat); end
    vectors++; if (r_serr !== 0) begin miscompares++; $display("FAIL divu_stall: got %0d bad cycles expected 0", r_serr); end
    vectors++; if (r_bsy !== 1'b1) begin miscompares++; $display("FAIL divu_busy_done: got %b expected 1", r_bsy); end
    @(negedge clk);
    vectors++; if ({busy, done, stall} !== 3'b000) begin miscompares++; $display("FAIL divu_after: got busy/done/stall %b expected 000", {busy, done, stall}); end
  endtask

  task automatic test_signed();
    exec(OP_REM, 32'hFFFF_FFF9, 2, 0, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL rem_neg: got %h expected ffffffff", r_res); end
    exec(OP_DIV, 32'hFFFF_FFF9, 2, 0, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg: got %h expected fffffffd", r_res); end
    vectors++; if (r_lat !== 33) begin miscompares++; $display("FAIL div_neg_latency: got %0d expected 33", r_lat); end
  endtask

  task automatic test_div_by_zero();
    exec(OP_DIVU, 32'h1234, 0, 0, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divu_zero: got %h expected ffffffff", r_res); end
    vectors++; if (r_lat !== 1) begin miscompares++; $display("FAIL divu_zero_latency: got %0d expected 1", r_lat); end
    vectors++; if (r_serr !== 0) begin miscompares++; $display("FAIL divu_zero_stall: got %0d bad cycles expected 0", r_serr); end
    exec(OP_REMU, 32'h1234, 0, 0, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== 32'h1234) begin miscompares++; $display("FAIL remu_zero: got %h expected 00001234", r_res); end
    exec(OP_REM, 32'hFFFF_FF00, 0, 0, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== 32'hFFFF_FF00) begin miscompares++; $display("FAIL rem_zero: got %h expected ffffff00", r_res); end
  endtask

  task automatic test_overflow();
    exec(OP_DIV, MINV, '1, 0, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== MINV) begin miscompares++; $display("FAIL ovf_div: got %h expected 80000000", r_res); end
    vectors++; if (r_lat !== 1) begin miscompares++; $display("FAIL ovf_latency: got %0d expected 1", r_lat); end
    exec(OP_REM, MINV, '1, 0, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== '0) begin miscompares++; $display("FAIL ovf_rem: got %h expected 0", r_res); end
  endtask

  task automatic test_operand_change();
    logic [W-1:0] x, y;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom | 32'h1;
      exec(2'(i), x, y, 0, 0, 1, r_res, r_lat, r_serr, r_bsy);
      vectors++; if (r_res !== ref_result(2'(i), x, y)) begin miscompares++; $display("FAIL toggle_result op=%0d: got %h expected %h", i, r_res, ref_result(2'(i), x, y)); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; a = 1000; b = 3;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    vectors++; if ({busy, done, stall} !== 3'b000) begin miscompares++; $display("FAIL midreset_state: got busy/done/stall %b expected 000", {busy, done, stall}); end
    vectors++; if (result !== '0) begin miscompares++; $display("FAIL midreset_result: got %h expected 0", result); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen = 1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midreset_nodone: got %b expected 0", seen); end
    exec(OP_DIV, 20, -32'sd4, 0, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== 32'hFFFF_FFFB) begin miscompares++; $display("FAIL midreset_div: got %h expected fffffffb", r_res); end
  endtask

  task automatic test_back_to_back();
    exec(OP_DIVU, 1000, 10, 0, 1, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== 32'd100) begin miscompares++; $display("FAIL b2b_first: got %h expected %h", r_res, 32'd100); end
    exec(OP_REM, 17, 5, 1, 1, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== 32'd2) begin miscompares++; $display("FAIL b2b_second: got %h expected 2", r_res); end
    vectors++; if (r_lat !== 33) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 33", r_lat); end
    exec(OP_DIVU, 5, 0, 1, 0, 0, r_res, r_lat, r_serr, r_bsy);
    vectors++; if (r_res !== '1) begin miscompares++; $display("FAIL b2b_third: got %h expected ffffffff", r_res); end
  endtask

  task automatic test_random();
    logic [1:0]   o;
    logic [W-1:0] x, y;
    bit           chain, keep;
    chain = 0;
    for (int i = 0; i < 1000; i++) begin
      o = 2'($urandom); x = pick(); y = pick();
      keep = (i != 999) && ($urandom_range(0, 3) == 0);
      exec(o, x, y, chain, keep, bit'($urandom_range(0, 1)), r_res, r_lat, r_serr, r_bsy);
      vectors++; if (r_res !== ref_result(o, x, y)) begin miscompares++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h expected %h", o, x, y, r_res, ref_result(o, x, y)); end
      vectors++; if (r_lat !== ref_latency(o, x, y)) begin miscompares++; $display("FAIL rand_latency op=%0d a=%h b=%h: got %0d expected %0d", o, x, y, r_lat, ref_latency(o, x, y)); end
      vectors++; if (r_serr !== 0) begin miscompares++; $display("FAIL rand_stall op=%0d a=%h b=%h: got %0d bad cycles expected 0", o, x, y, r_serr); end
      chain = keep;
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_operand_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
